// File: rtl/endpoint_select_ctrl.sv
// Endpoint sequencer between the city-hit detector and the shortest-path search engine.
// Optional build macro ENDPOINT_DESELECT_EN: clicking the begin city again deselects it.
module endpoint_select_ctrl #(
    parameter int unsigned HOLDOFF_CYCLES = 2500000,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned CW             = 10
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          LEFT,
    input  logic          RIGHT,
    input  logic [CW-1:0] pos_x_in,
    input  logic [CW-1:0] pos_y_in,
    input  logic          search_done,
    output logic [CW-1:0] begin_x,
    output logic [CW-1:0] begin_y,
    output logic [CW-1:0] end_x,
    output logic [CW-1:0] end_y,
    output logic          begin_valid,
    output logic          end_valid,
    output logic          search_start,
    output logic          search_abort,
    output logic          busy,
    output logic          timeout_err,
    output logic [2:0]    state_out
);

    localparam int unsigned HO_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GOT_BEGIN = 3'd1,
        S_GOT_END   = 3'd2,
        S_START     = 3'd3,
        S_BUSY      = 3'd4,
        S_SHOW      = 3'd5
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            hit;
    logic            hit_d;
    logic            right_d;
    logic            click;
    logic            cancel;
    logic [HO_W-1:0] holdoff;
    logic [TO_W-1:0] tmo_cnt;
    logic            tmo_hit;

    logic [CW-1:0]   begin_x_nxt;
    logic [CW-1:0]   begin_y_nxt;
    logic [CW-1:0]   end_x_nxt;
    logic [CW-1:0]   end_y_nxt;
    logic            begin_valid_nxt;
    logic            end_valid_nxt;
    logic            abort_nxt;
    logic            timeout_err_nxt;
    logic            start_nxt;
    logic            busy_nxt;
    logic            same_as_begin;

    // Edge-qualified click and cancel; holdoff suppresses bounce after an accepted click
    assign hit           = LEFT && ((pos_x_in != '0) || (pos_y_in != '0));
    assign click         = hit && !hit_d && (holdoff == '0);
    assign cancel        = RIGHT && !right_d;
    assign tmo_hit       = (tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign same_as_begin = (pos_x_in == begin_x) && (pos_y_in == begin_y);
    assign state_out     = state;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            hit_d   <= 1'b0;
            right_d <= 1'b0;
            holdoff <= '0;
            tmo_cnt <= '0;
        end else begin
            hit_d   <= hit;
            right_d <= RIGHT;
            if (click) begin
                holdoff <= HO_W'(HOLDOFF_CYCLES);
            end else if (holdoff != '0) begin
                holdoff <= holdoff - HO_W'(1);
            end
            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if (state == S_BUSY) begin
                tmo_cnt <= tmo_cnt + TO_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        begin_x_nxt     = begin_x;
        begin_y_nxt     = begin_y;
        end_x_nxt       = end_x;
        end_y_nxt       = end_y;
        begin_valid_nxt = begin_valid;
        end_valid_nxt   = end_valid;
        timeout_err_nxt = timeout_err;
        abort_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (click && !cancel) begin
                    begin_x_nxt     = pos_x_in;
                    begin_y_nxt     = pos_y_in;
                    begin_valid_nxt = 1'b1;
                    end_valid_nxt   = 1'b0;
                    timeout_err_nxt = 1'b0;
                    state_nxt       = S_GOT_BEGIN;
                end
            end
            S_GOT_BEGIN: begin
                if (cancel) begin
                    begin_valid_nxt = 1'b0;
                    end_valid_nxt   = 1'b0;
                    state_nxt       = S_IDLE;
                end else if (click) begin
                    if (!same_as_begin) begin
                        end_x_nxt     = pos_x_in;
                        end_y_nxt     = pos_y_in;
                        end_valid_nxt = 1'b1;
                        state_nxt     = S_GOT_END;
                    end else begin
`ifdef ENDPOINT_DESELECT_EN
                        begin_valid_nxt = 1'b0;
                        state_nxt       = S_IDLE;
`else
                        state_nxt       = S_GOT_BEGIN;
`endif
                    end
                end
            end
            S_GOT_END: begin
                if (cancel) begin
                    begin_valid_nxt = 1'b0;
                    end_valid_nxt   = 1'b0;
                    state_nxt       = S_IDLE;
                end else begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // Cancel beats done, done beats timeout
                if (cancel) begin
                    abort_nxt       = 1'b1;
                    begin_valid_nxt = 1'b0;
                    end_valid_nxt   = 1'b0;
                    state_nxt       = S_IDLE;
                end else if (search_done) begin
                    state_nxt = S_SHOW;
                end else if (tmo_hit) begin
                    timeout_err_nxt = 1'b1;
                    begin_valid_nxt = 1'b0;
                    end_valid_nxt   = 1'b0;
                    state_nxt       = S_IDLE;
                end
            end
            S_SHOW: begin
                if (cancel) begin
                    begin_valid_nxt = 1'b0;
                    end_valid_nxt   = 1'b0;
                    state_nxt       = S_IDLE;
                end else if (click) begin
                    begin_x_nxt     = pos_x_in;
                    begin_y_nxt     = pos_y_in;
                    begin_valid_nxt = 1'b1;
                    end_valid_nxt   = 1'b0;
                    state_nxt       = S_GOT_BEGIN;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        start_nxt = (state_nxt == S_START);
        busy_nxt  = (state_nxt == S_START) || (state_nxt == S_BUSY);
    end

    // Outputs registered alongside the state so they line up with state_out
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            begin_x      <= '0;
            begin_y      <= '0;
            end_x        <= '0;
            end_y        <= '0;
            begin_valid  <= 1'b0;
            end_valid    <= 1'b0;
            search_start <= 1'b0;
            search_abort <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            begin_x      <= begin_x_nxt;
            begin_y      <= begin_y_nxt;
            end_x        <= end_x_nxt;
            end_y        <= end_y_nxt;
            begin_valid  <= begin_valid_nxt;
            end_valid    <= end_valid_nxt;
            search_start <= start_nxt;
            search_abort <= abort_nxt;
            busy         <= busy_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_endpoint_select_ctrl.sv
// Directed bench for endpoint_select_ctrl; endpoint pairs are scoreboarded at search_start.
module tb_endpoint_select_ctrl;

    localparam int HO = 1000;
    localparam int TO = 64;
    localparam int CW = 10;

    typedef struct packed {
        logic [CW-1:0] bx;
        logic [CW-1:0] by;
        logic [CW-1:0] ex;
        logic [CW-1:0] ey;
    } ep_t;

    logic          Clk;
    logic          Reset;
    logic          LEFT;
    logic          RIGHT;
    logic [CW-1:0] pos_x_in;
    logic [CW-1:0] pos_y_in;
    logic          search_done;
    logic [CW-1:0] begin_x;
    logic [CW-1:0] begin_y;
    logic [CW-1:0] end_x;
    logic [CW-1:0] end_y;
    logic          begin_valid;
    logic          end_valid;
    logic          search_start;
    logic          search_abort;
    logic          busy;
    logic          timeout_err;
    logic [2:0]    state_out;

    int  n_tests = 0;
    int  n_fail  = 0;
    ep_t sb[$];

    endpoint_select_ctrl #(
        .HOLDOFF_CYCLES(HO),
        .TIMEOUT_CYCLES(TO),
        .CW(CW)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .LEFT(LEFT),
        .RIGHT(RIGHT),
        .pos_x_in(pos_x_in),
        .pos_y_in(pos_y_in),
        .search_done(search_done),
        .begin_x(begin_x),
        .begin_y(begin_y),
        .end_x(end_x),
        .end_y(end_y),
        .begin_valid(begin_valid),
        .end_valid(end_valid),
        .search_start(search_start),
        .search_abort(search_abort),
        .busy(busy),
        .timeout_err(timeout_err),
        .state_out(state_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic click(input int x, input int y);
        LEFT     = 1'b1;
        pos_x_in = CW'(x);
        pos_y_in = CW'(y);
        tick();
        LEFT     = 1'b0;
        pos_x_in = '0;
        pos_y_in = '0;
    endtask

    task automatic wait_holdoff();
        repeat (HO + 2) tick();
    endtask

    task automatic reset_pulse();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    // Waits (bounded) for search_start, checks latency and the scoreboarded endpoints
    task automatic wait_start(input int exp_lat);
        int  n;
        ep_t e;
        n = 0;
        while (search_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(search_start), 1);
        chk("start_latency", 32'(n), 32'(exp_lat));
        chk("sb_depth", 32'(sb.size()), 1);
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        chk("sb_begin_x", 32'(begin_x), 32'(e.bx));
        chk("sb_begin_y", 32'(begin_y), 32'(e.by));
        chk("sb_end_x", 32'(end_x), 32'(e.ex));
        chk("sb_end_y", 32'(end_y), 32'(e.ey));
        chk("start_busy", 32'(busy), 1);
    endtask

    initial begin
        Reset = 1'b0; LEFT = 1'b0; RIGHT = 1'b0;
        pos_x_in = '0; pos_y_in = '0; search_done = 1'b0;

        // Reset
        tick(); tick();
        Reset = 1'b1;
        chk("rst_state", 32'(state_out), 0);
        chk("rst_outs", 32'({begin_x, begin_y, end_x, end_y}), 0);
        chk("rst_flags", 32'({begin_valid, end_valid, search_start, search_abort, busy, timeout_err}), 0);
        tick();
        chk("post_rst_state", 32'(state_out), 0);

        // Normal selection and search
        click(465, 186);
        chk("b1_state", 32'(state_out), 1);
        chk("b1_valid", 32'(begin_valid), 1);
        chk("b1_x", 32'(begin_x), 465);
        chk("b1_y", 32'(begin_y), 186);
        chk("b1_evalid", 32'(end_valid), 0);
        wait_holdoff();
        sb.push_back('{bx: CW'(465), by: CW'(186), ex: CW'(530), ey: CW'(301)});
        click(530, 301);
        chk("e1_state", 32'(state_out), 2);
        chk("e1_evalid", 32'(end_valid), 1);
        chk("e1_start_early", 32'(search_start), 0);
        wait_start(1);
        chk("start_state", 32'(state_out), 3);
        tick();
        chk("start_one_cycle", 32'(search_start), 0);
        chk("busy_state", 32'(state_out), 4);
        repeat (10) tick();
        chk("busy_wait_state", 32'(state_out), 4);
        search_done = 1'b1;
        tick();
        search_done = 1'b0;
        chk("show_state", 32'(state_out), 5);
        chk("show_busy", 32'(busy), 0);
        chk("show_evalid", 32'(end_valid), 1);

        // Re-selection from SHOW
        wait_holdoff();
        click(111, 222);
        chk("resel_state", 32'(state_out), 1);
        chk("resel_bx", 32'(begin_x), 111);
        chk("resel_evalid", 32'(end_valid), 0);
        chk("resel_ex_kept", 32'(end_x), 530);

        // Holdoff: second click 100 cycles later ignored
        reset_pulse();
        chk("ho_rst_state", 32'(state_out), 0);
        click(100, 200);
        chk("ho_first", 32'(state_out), 1);
        repeat (100) tick();
        click(300, 400);
        tick();
        chk("ho_second_state", 32'(state_out), 1);
        chk("ho_second_evalid", 32'(end_valid), 0);
        chk("ho_bx", 32'(begin_x), 100);

        // LEFT held for 5000 cycles gives a single click
        reset_pulse();
        LEFT = 1'b1; pos_x_in = CW'(50); pos_y_in = CW'(60);
        repeat (5000) tick();
        chk("held_state", 32'(state_out), 1);
        chk("held_bx", 32'(begin_x), 50);
        chk("held_evalid", 32'(end_valid), 0);
        LEFT = 1'b0; pos_x_in = '0; pos_y_in = '0;
        tick();

        // Timeout in BUSY
        reset_pulse();
        click(10, 20);
        wait_holdoff();
        sb.push_back('{bx: CW'(10), by: CW'(20), ex: CW'(30), ey: CW'(40)});
        click(30, 40);
        wait_start(1);
        repeat (TO) tick();
        chk("to_last_busy", 32'(state_out), 4);
        chk("to_not_yet", 32'(timeout_err), 0);
        tick();
        chk("to_err", 32'(timeout_err), 1);
        chk("to_state", 32'(state_out), 0);
        chk("to_bvalid", 32'(begin_valid), 0);
        chk("to_busy", 32'(busy), 0);
        wait_holdoff();
        chk("to_sticky", 32'(timeout_err), 1);
        click(5, 6);
        chk("to_cleared", 32'(timeout_err), 0);
        chk("to_click_state", 32'(state_out), 1);

        // Cancel and done together in BUSY: cancel wins
        wait_holdoff();
        sb.push_back('{bx: CW'(5), by: CW'(6), ex: CW'(7), ey: CW'(8)});
        click(7, 8);
        wait_start(1);
        tick();
        RIGHT = 1'b1; search_done = 1'b1;
        tick();
        search_done = 1'b0;
        chk("cx_state", 32'(state_out), 0);
        chk("cx_abort", 32'(search_abort), 1);
        chk("cx_bvalid", 32'(begin_valid), 0);
        tick();
        chk("cx_abort_pulse", 32'(search_abort), 0);
        chk("cx_no_show", 32'(state_out), 0);
        RIGHT = 1'b0;
        tick();

        // Same-city second click
        wait_holdoff();
        click(465, 186);
        chk("ds_first", 32'(state_out), 1);
        wait_holdoff();
        click(465, 186);
        tick();
`ifdef ENDPOINT_DESELECT_EN
        chk("ds_state", 32'(state_out), 0);
        chk("ds_bvalid", 32'(begin_valid), 0);
`else
        chk("ds_state", 32'(state_out), 1);
        chk("ds_bvalid", 32'(begin_valid), 1);
        chk("ds_bx", 32'(begin_x), 465);
        RIGHT = 1'b1;
        tick();
        RIGHT = 1'b0;
        chk("ds_cancel_state", 32'(state_out), 0);
        chk("ds_cancel_bvalid", 32'(begin_valid), 0);
`endif
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/endpoint_select_ctrl.md
Name: endpoint_select_ctrl

Overview:
- Sequencer between the mouse city-hit detector and the shortest-path search engine on the railway map.
- Converts the detector's per-cycle snapped city coordinates into two registered endpoints: first accepted click is the begin city, second is the end city.
- Issues a one-cycle start to the search engine and waits for its done. Handles cancel, timeout and re-selection.

Parameters:
- HOLDOFF_CYCLES, 2500000, cycles after an accepted click during which further clicks are ignored (50 ms at 50 MHz).
- TIMEOUT_CYCLES, 50000000, maximum cycles in BUSY before the search is abandoned.
- CW, 10, coordinate width in bits.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- LEFT  in  1  left mouse button, level.
- RIGHT  in  1  right mouse button, level; cancel.
- pos_x_in  in  CW  snapped city X from the detector; 0 means no city hit.
- pos_y_in  in  CW  snapped city Y from the detector; 0 means no city hit.
- search_done  in  1  pulse or level from the search engine; sampled only in BUSY.
- begin_x, begin_y  out  CW  registered begin city.
- end_x, end_y  out  CW  registered end city.
- begin_valid  out  1  begin city captured.
- end_valid  out  1  end city captured.
- search_start  out  1  one-cycle start pulse.
- search_abort  out  1  one-cycle abort pulse.
- busy  out  1  high in START and BUSY.
- timeout_err  out  1  sticky timeout flag.
- state_out  out  3  current state encoding, for debug and display.

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - All outputs go to 0; state goes to IDLE; both counters clear.
  - Reset overrides every other event, including mid-search. No abort pulse is issued on reset.
- Hit and click detection:
  - hit = LEFT && (pos_x_in!=0 || pos_y_in!=0).
  - hit_d is hit registered by one cycle.
  - click = hit && !hit_d && (holdoff==0).
  - An accepted click loads holdoff with HOLDOFF_CYCLES. holdoff decrements to 0 and saturates there.
  - Coordinates are latched from pos_x_in/pos_y_in in the click cycle and appear on outputs the next cycle.
- Cancel:
  - cancel = RIGHT && !RIGHT_d (rising edge).
  - It takes priority over click in the same cycle.
- States and transitions:
  - IDLE (0): click -> latch begin, begin_valid=1, go to GOT_BEGIN.
  - GOT_BEGIN (1):
    - Click on coordinates different from begin -> latch end, end_valid=1, go to GOT_END.
    - Click equal to begin -> see Optional Feature.
    - cancel -> clear both valids, go to IDLE.
  - GOT_END (2): unconditional next cycle -> START. cancel in this cycle -> IDLE.
  - START (3): search_start=1 for exactly this cycle, clear the timeout counter, go to BUSY. Latency from accepted end click to search_start is 2 cycles.
  - BUSY (4):
    - Counter increments each cycle.
    - search_done -> SHOW.
    - Counter reaching TIMEOUT_CYCLES-1 without done -> timeout_err=1, clear valids, IDLE.
    - cancel -> search_abort=1 for one cycle, clear valids, IDLE.
    - Clicks in BUSY are ignored, but still load holdoff.
    - If done and cancel arrive in the same cycle, cancel wins.
  - SHOW (5):
    - Endpoints are held for path display.
    - click -> new begin latched, end_valid=0, go to GOT_BEGIN.
    - cancel -> IDLE with valids cleared.
- timeout_err clears on Reset or on the next accepted click in IDLE.
- begin/end coordinate registers keep their last values when the valids clear; consumers must qualify them with the valid bits.
- Encodings 6 and 7 are unreachable and recover to IDLE.
- A button held across a state change does not generate a second click. Only a new hit rising edge counts.

Optional Feature:
- Macro: ENDPOINT_DESELECT_EN.
- Defined: in GOT_BEGIN, a click whose coordinates equal begin clears begin_valid and returns to IDLE (toggle deselect).
- Undefined: that click is ignored; state and begin are unchanged. Holdoff is still loaded in both builds.

Test Plan:
- Reset low 2 cycles, then high -> all outputs 0, state_out=0.
- Click at (465,186), wait holdoff, click at (530,301) -> begin=(465,186), end=(530,301), search_start one cycle exactly 2 cycles after the second click; hold done low 10 cycles then high 1 cycle -> state_out=5, busy=0.
- Two clicks 100 cycles apart with HOLDOFF_CYCLES=1000 -> second click ignored, state stays 1. LEFT held 5000 cycles -> only one click accepted.
- In BUSY with TIMEOUT_CYCLES=64, no done -> timeout_err=1 after 64 cycles, state 0, begin_valid=0. Next click in IDLE clears timeout_err.
- In BUSY, RIGHT rising edge and search_done in the same cycle -> search_abort=1 for one cycle, state 0, no SHOW.
- Begin (465,186), then click (465,186) again -> with ENDPOINT_DESELECT_EN: state 0, begin_valid=0; without: state 1, begin_valid=1.
